// File: rtl/patp_pkg.sv
// Shared definitions for the PATP main store and its program loader.
//   ADDR_W / DATA_W : default store address and word widths
//   MS_DEPTH        : number of words in the main store
//   loader_state_t  : states of the framed-program loader
package patp_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned MS_DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    HEADER,
    DATA,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// Program loader: fills the PATP main store from a framed byte stream
// (length byte, data bytes, checksum byte) and holds the core until a
// load completes with a good checksum.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   start      : one-cycle pulse, re-arms a load from DONE or ERROR
//   in_valid   : stream byte valid
//   in_data    : stream byte
//   in_ready   : loader can accept a byte
//   ld_write   : one-cycle store write strobe
//   ld_addr    : store write address
//   ld_data    : store write data
//   core_hold  : high while the core must stay held
//   done       : load finished, checksum good
//   error      : load failed (bad length or bad checksum)
module prog_loader
  import patp_pkg::*;
#(
  parameter int unsigned ADDR_W = patp_pkg::ADDR_W,
  parameter int unsigned DATA_W = patp_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ld_write,
  output logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  // Length is held one bit wider than the index so a full-depth load fits.
  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W + 1)'(1);
  localparam logic [DATA_W-1:0] DEPTH_B = DATA_W'(DEPTH);

  loader_state_t     state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              ld_write_q, ld_write_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic              ready_q, ready_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept;
  logic [ADDR_W:0]   count_next;

  assign accept     = in_valid && ready_q;
  assign count_next = {1'b0, idx_q} + LEN_ONE;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    ld_write_d = 1'b0;
    ld_addr_d  = ld_addr_q;
    ld_data_d  = ld_data_q;

    unique case (state_q)
      HEADER: begin
        if (accept) begin
          idx_d = '0;
          sum_d = '0;
          if (in_data == '0) begin
            len_d   = DEPTH;
            state_d = DATA;
          end else if (in_data <= DEPTH_B) begin
            len_d   = in_data[ADDR_W:0];
            state_d = DATA;
          end else begin
            state_d = ERROR;
          end
        end
      end
      DATA: begin
        if (accept) begin
          ld_write_d = 1'b1;
          ld_addr_d  = idx_q;
          ld_data_d  = in_data;
          sum_d      = sum_q + in_data;
          idx_d      = idx_q + ADDR_W'(1);
          if (count_next == len_q) state_d = CHECK;
        end
      end
      CHECK: begin
        if (accept) state_d = (in_data == sum_q) ? DONE : ERROR;
      end
      DONE, ERROR: begin
        if (start) state_d = HEADER;
      end
      default: state_d = HEADER;
    endcase

    // Status outputs are registered from the next state so they settle in
    // the cycle after the deciding acceptance.
    ready_d = (state_d == HEADER) || (state_d == DATA) || (state_d == CHECK);
    hold_d  = (state_d != DONE);
    done_d  = (state_d == DONE);
    error_d = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= HEADER;
      len_q      <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      ld_write_q <= 1'b0;
      ld_addr_q  <= '0;
      ld_data_q  <= '0;
      ready_q    <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      ld_write_q <= ld_write_d;
      ld_addr_q  <= ld_addr_d;
      ld_data_q  <= ld_data_d;
      ready_q    <= ready_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign in_ready  = ready_q;
  assign ld_write  = ld_write_q;
  assign ld_addr   = ld_addr_q;
  assign ld_data   = ld_data_q;
  assign core_hold = hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       ld_write;
  logic [4:0] ld_addr;
  logic [7:0] ld_data;
  logic       core_hold;
  logic       done;
  logic       error;

  prog_loader #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ld_write(ld_write), .ld_addr(ld_addr), .ld_data(ld_data),
    .core_hold(core_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int both_high = 0;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;
  wr_t got[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ld_write === 1'b1) got.push_back('{int'(ld_addr), int'(ld_data), cyc});
    if (done === 1'b1 && error === 1'b1) both_high++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_rearm_done"}, done, 0);
    chk({tag, "_rearm_error"}, error, 0);
    chk({tag, "_rearm_hold"}, core_hold, 1);
    chk({tag, "_rearm_ready"}, in_ready, 1);
  endtask

  // Reference: a frame writes its data bytes to consecutive addresses from 0,
  // succeeds only if the checksum equals the byte sum mod 256.
  task automatic run_frame(input string tag, input logic [7:0] hdr, input int cks_off,
                           input int gapmax, input int exp_done, input int exp_err,
                           input int exp_nwr);
    logic [7:0] d[$];
    logic [7:0] sum;
    logic [7:0] b;
    int len;
    got.delete();
    sum = 8'h00;
    len = (hdr == 8'h00) ? 32 : int'(hdr);
    send_byte(hdr, $urandom_range(0, gapmax));
    if (len <= 32) begin
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        d.push_back(b);
        sum = sum + b;
        send_byte(b, $urandom_range(0, gapmax));
      end
      send_byte(sum + 8'(cks_off), $urandom_range(0, gapmax));
    end
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_error"}, error, exp_err);
    tick();
    tick();
    chk({tag, "_nwr"}, got.size(), exp_nwr);
    for (int i = 0; i < got.size() && i < d.size(); i++) begin
      chk({tag, "_addr"}, got[i].addr, i);
      chk({tag, "_data"}, got[i].data, d[i]);
    end
    chk({tag, "_hold"}, core_hold, (exp_done != 0) ? 0 : 1);
    chk({tag, "_ready"}, in_ready, 0);
    pulse_start(tag);
  endtask

  typedef struct {
    logic [7:0] hdr;
    int cks_off;
    int gapmax;
    int exp_done;
    int exp_err;
    int exp_nwr;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[$];
    logic [7:0] seq[$];
    int rh, roff, rlen, rdone, rerr, rnwr;

    vt.push_back('{8'h01, 0, 0, 1, 0, 1});
    vt.push_back('{8'h20, 0, 2, 1, 0, 32});
    vt.push_back('{8'h05, 7, 1, 0, 1, 5});
    vt.push_back('{8'h21, 0, 0, 0, 1, 0});
    vt.push_back('{8'hFF, 0, 0, 0, 1, 0});
    vt.push_back('{8'h02, 0, 3, 1, 0, 2});
    vt.push_back('{8'h1F, 255, 0, 0, 1, 31});

    // Reset state
    #12;
    chk("rst_ready", in_ready, 0);
    chk("rst_write", ld_write, 0);
    chk("rst_addr", ld_addr, 0);
    chk("rst_data", ld_data, 0);
    chk("rst_hold", core_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_ready_pre", in_ready, 0);
    tick();
    chk("rel_ready", in_ready, 1);
    repeat (5) tick();
    chk("idle_nwr", got.size(), 0);
    chk("idle_hold", core_hold, 1);
    chk("idle_done", done, 0);

    // Back-to-back good frame
    got.delete();
    seq = '{8'h03, 8'h10, 8'h20, 8'h05, 8'h35};
    foreach (seq[i]) send_byte(seq[i], 0);
    chk("b2b_done", done, 1);
    chk("b2b_hold", core_hold, 0);
    chk("b2b_nwr", got.size(), 3);
    if (got.size() == 3) begin
      chk("b2b_a0", got[0].addr, 0);
      chk("b2b_d0", got[0].data, 8'h10);
      chk("b2b_a1", got[1].addr, 1);
      chk("b2b_d1", got[1].data, 8'h20);
      chk("b2b_a2", got[2].addr, 2);
      chk("b2b_d2", got[2].data, 8'h05);
      chk("b2b_consec1", got[1].cyc - got[0].cyc, 1);
      chk("b2b_consec2", got[2].cyc - got[1].cyc, 1);
    end
    pulse_start("b2b");

    // Same frame, bad checksum
    got.delete();
    seq = '{8'h03, 8'h10, 8'h20, 8'h05, 8'h36};
    foreach (seq[i]) send_byte(seq[i], 0);
    chk("badck_error", error, 1);
    chk("badck_done", done, 0);
    chk("badck_hold", core_hold, 1);
    chk("badck_nwr", got.size(), 3);
    pulse_start("badck");

    // Oversized header
    got.delete();
    send_byte(8'h21, 0);
    chk("hdr21_error", error, 1);
    chk("hdr21_ready", in_ready, 0);
    repeat (3) tick();
    chk("hdr21_nwr", got.size(), 0);
    pulse_start("hdr21");

    // Full-depth load with gaps
    got.delete();
    send_byte(8'h00, 0);
    for (int i = 0; i < 32; i++) send_byte(8'h01, $urandom_range(0, 2));
    send_byte(8'h20, 1);
    repeat (2) tick();
    chk("full_done", done, 1);
    chk("full_nwr", got.size(), 32);
    for (int i = 0; i < got.size() && i < 32; i++) begin
      chk("full_addr", got[i].addr, i);
      chk("full_data", got[i].data, 1);
    end
    pulse_start("full");

    // Reset during DATA after the second byte
    got.delete();
    send_byte(8'h05, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2 rst = 1'b0;
    #1;
    chk("mid_write", ld_write, 0);
    chk("mid_addr", ld_addr, 0);
    chk("mid_data", ld_data, 0);
    chk("mid_ready", in_ready, 0);
    chk("mid_hold", core_hold, 1);
    chk("mid_done", done, 0);
    chk("mid_error", error, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("mid_rel_ready", in_ready, 1);
    run_frame("after_rst", 8'h04, 0, 0, 1, 0, 4);

    // Table of frames
    foreach (vt[i]) run_frame("tab", vt[i].hdr, vt[i].cks_off, vt[i].gapmax,
                              vt[i].exp_done, vt[i].exp_err, vt[i].exp_nwr);

    // Random frames against the reference outcome
    for (int k = 0; k < 25; k++) begin
      rh   = $urandom_range(0, 40);
      roff = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : 0;
      rlen = (rh == 0) ? 32 : rh;
      if (rlen > 32) begin
        rdone = 0; rerr = 1; rnwr = 0;
      end else begin
        rdone = (roff == 0) ? 1 : 0;
        rerr  = 1 - rdone;
        rnwr  = rlen;
      end
      run_frame("rand", 8'(rh), roff, 2, rdone, rerr, rnwr);
    end

    chk("never_both", both_high, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
